// File: rtl/wb_timer_pkg.sv
// wb_timer_pkg: shared definitions for the Wishbone prescaled timer.
//   - byte offsets of every register and the matching register indices
//   - CTRL / STATUS bit positions
//   - bus handshake state type
//   - byte-lane mask helper for wb_sel_i
package wb_timer_pkg;

  localparam int REG_IDX_W = 3;

  localparam logic [4:0] ADDR_CTRL     = 5'h00;
  localparam logic [4:0] ADDR_PRESCALE = 5'h04;
  localparam logic [4:0] ADDR_COUNT    = 5'h08;
  localparam logic [4:0] ADDR_COMPARE  = 5'h0C;
  localparam logic [4:0] ADDR_STATUS   = 5'h10;
  localparam logic [4:0] ADDR_CAPTURE  = 5'h14;

  localparam logic [REG_IDX_W-1:0] IDX_CTRL     = ADDR_CTRL[4:2];
  localparam logic [REG_IDX_W-1:0] IDX_PRESCALE = ADDR_PRESCALE[4:2];
  localparam logic [REG_IDX_W-1:0] IDX_COUNT    = ADDR_COUNT[4:2];
  localparam logic [REG_IDX_W-1:0] IDX_COMPARE  = ADDR_COMPARE[4:2];
  localparam logic [REG_IDX_W-1:0] IDX_STATUS   = ADDR_STATUS[4:2];
  localparam logic [REG_IDX_W-1:0] IDX_CAPTURE  = ADDR_CAPTURE[4:2];

  // CTRL bits
  localparam int CTRL_W        = 5;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_AUTO     = 1;
  localparam int CTRL_IE_MATCH = 2;
  localparam int CTRL_IE_OVF   = 3;
  localparam int CTRL_IE_CAP   = 4;

  // STATUS bits (all write-1-to-clear)
  localparam int STATUS_W   = 3;
  localparam int STAT_MATCH = 0;
  localparam int STAT_OVF   = 1;
  localparam int STAT_CAP   = 2;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  // Expand the 4 byte-lane enables into a 32-bit bit mask.
  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) begin
      mask[b*8 +: 8] = {8{sel[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// wb_timer_prescaler: free-running prescale counter producing the timer tick.
//   clk_i    in  system clock
//   rst_i    in  asynchronous active-high reset
//   en       in  count enable; when low the counter holds its value
//   clear    in  synchronous clear (software rewrote COUNT or PRESCALE)
//   prescale in  terminal value; the counter runs 0..prescale
//   tick     out high in the cycle the counter equals prescale while enabled
module wb_timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_reg;

  // prescale == 0 makes this true every enabled cycle.
  assign tick = en & (cnt_reg == prescale);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (clear || tick) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/wb_timer_irq.sv
// wb_timer_irq: Wishbone classic slave with a 32-bit prescaled timer,
// compare-match and overflow events and a registered level interrupt.
//
// Optional feature macro: WB_TIMER_CAPTURE_EN
//   defined   -> capture_i is synchronised (2 FF) and its rising edge copies
//                COUNT into CAPTURE, sets STATUS.CAP; CTRL.IE_CAP gates irq.
//   undefined -> capture_i is ignored; CAPTURE, STATUS[2], CTRL[4] read 0.
//
// Ports
//   clk_i      in   system clock, rising edge
//   rst_i      in   asynchronous active-high reset
//   wb_adr_i   in   byte address, register index = wb_adr_i[4:2]
//   wb_dat_i   in   write data
//   wb_sel_i   in   byte-lane write enables
//   wb_we_i    in   write enable
//   wb_cyc_i   in   bus cycle
//   wb_stb_i   in   strobe
//   wb_dat_o   out  read data, valid while wb_ack_o is high
//   wb_ack_o   out  single-cycle acknowledge (every access takes 2 cycles)
//   irq_o      out  registered level interrupt
//   capture_i  in   asynchronous capture strobe
//
// Register map: 0x00 CTRL, 0x04 PRESCALE, 0x08 COUNT, 0x0C COMPARE,
//               0x10 STATUS (W1C), 0x14 CAPTURE (RO); others read 0.
module wb_timer_irq
  import wb_timer_pkg::*;
#(
  parameter int          PRESCALE_W  = 16,
  parameter logic [31:0] RST_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        irq_o,
  input  logic        capture_i
);

`ifdef WB_TIMER_CAPTURE_EN
  localparam logic [CTRL_W-1:0]   CTRL_WMASK   = 5'h1F;
  localparam logic [STATUS_W-1:0] STATUS_WMASK = 3'h7;
`else
  localparam logic [CTRL_W-1:0]   CTRL_WMASK   = 5'h0F;
  localparam logic [STATUS_W-1:0] STATUS_WMASK = 3'h3;
`endif

  // ---------------------------------------------------------------------
  // Bus handshake
  // ---------------------------------------------------------------------
  bus_state_e state_reg, state_next;
  logic [REG_IDX_W-1:0] reg_idx;
  logic                 bus_req;
  logic                 bus_write;
  logic [31:0]          rd_data;
  logic [31:0]          dat_reg;

  assign reg_idx  = wb_adr_i[4:2];
  assign bus_req  = wb_cyc_i & wb_stb_i;
  assign wb_ack_o = (state_reg == BUS_ACK);
  assign wb_dat_o = dat_reg;
  // The master holds address/data until ack, so the write uses the
  // inputs present during the ack cycle.
  assign bus_write = (state_reg == BUS_ACK) & bus_req & wb_we_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= BUS_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BUS_IDLE: if (bus_req) state_next = BUS_ACK;
      BUS_ACK:  state_next = BUS_IDLE;   // never back-to-back acks
      default:  state_next = BUS_IDLE;
    endcase
  end

  // Read data is captured on the same edge that raises ack, and is zero
  // whenever ack is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dat_reg <= 32'h0;
    end else if ((state_reg == BUS_IDLE) && bus_req && !wb_we_i) begin
      dat_reg <= rd_data;
    end else begin
      dat_reg <= 32'h0;
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic [CTRL_W-1:0]     ctrl_reg;
  logic [PRESCALE_W-1:0] prescale_reg;
  logic [31:0]           count_reg, count_next;
  logic [31:0]           compare_reg;
  logic [STATUS_W-1:0]   status_reg, status_next;
  logic                  irq_reg;
  logic [31:0]           capture_val;
  logic                  cap_rise;

  logic [31:0] byte_mask;
  logic [31:0] wr_data;
  logic        wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;

  assign byte_mask   = sel_to_mask(wb_sel_i);
  // Byte-merge the incoming data over the current value of the addressed
  // register, so unselected lanes keep their contents.
  assign wr_data     = (rd_data & ~byte_mask) | (wb_dat_i & byte_mask);
  assign wr_ctrl     = bus_write & (reg_idx == IDX_CTRL);
  assign wr_prescale = bus_write & (reg_idx == IDX_PRESCALE);
  assign wr_count    = bus_write & (reg_idx == IDX_COUNT);
  assign wr_compare  = bus_write & (reg_idx == IDX_COMPARE);
  assign wr_status   = bus_write & (reg_idx == IDX_STATUS);

  always_comb begin
    rd_data = 32'h0;
    case (reg_idx)
      IDX_CTRL:     rd_data = 32'(ctrl_reg);
      IDX_PRESCALE: rd_data = 32'(prescale_reg);
      IDX_COUNT:    rd_data = count_reg;
      IDX_COMPARE:  rd_data = compare_reg;
      IDX_STATUS:   rd_data = 32'(status_reg);
      IDX_CAPTURE:  rd_data = capture_val;
      default:      rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_reg     <= '0;
      prescale_reg <= '0;
      compare_reg  <= RST_COMPARE;
    end else begin
      if (wr_ctrl)     ctrl_reg     <= wr_data[CTRL_W-1:0] & CTRL_WMASK;
      if (wr_prescale) prescale_reg <= wr_data[PRESCALE_W-1:0];
      if (wr_compare)  compare_reg  <= wr_data;
    end
  end

  // ---------------------------------------------------------------------
  // Timer core
  // ---------------------------------------------------------------------
  logic tick;
  logic hit_compare;
  logic reload;
  logic [STATUS_W-1:0] status_set;
  logic [STATUS_W-1:0] status_clr;

  wb_timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en       (ctrl_reg[CTRL_EN]),
    .clear    (wr_count | wr_prescale),
    .prescale (prescale_reg),
    .tick     (tick)
  );

  assign hit_compare = (count_reg == compare_reg);
  assign reload      = tick & hit_compare & ctrl_reg[CTRL_AUTO];

  always_comb begin
    count_next = count_reg;
    if (wr_count) begin
      count_next = wr_data;               // software write beats a tick
    end else if (tick) begin
      count_next = reload ? 32'h0 : count_reg + 32'd1;
    end
  end

  always_comb begin
    status_set             = '0;
    status_set[STAT_MATCH] = tick & hit_compare;
    // An AUTO reload at all-ones takes priority over wrapping.
    status_set[STAT_OVF]   = tick & (&count_reg) & ~reload;
    status_set[STAT_CAP]   = cap_rise;
    status_clr  = wr_status ? (wb_dat_i[STATUS_W-1:0] & byte_mask[STATUS_W-1:0]) : '0;
    // Clear first, then set: a hardware event in the same cycle wins.
    status_next = ((status_reg & ~status_clr) | status_set) & STATUS_WMASK;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_reg  <= 32'h0;
      status_reg <= '0;
      irq_reg    <= 1'b0;
    end else begin
      count_reg  <= count_next;
      status_reg <= status_next;
      // Built from the current registers, so irq follows status/enable
      // changes one cycle later.
      irq_reg    <= (status_reg[STAT_MATCH] & ctrl_reg[CTRL_IE_MATCH]) |
                    (status_reg[STAT_OVF]   & ctrl_reg[CTRL_IE_OVF])   |
                    (status_reg[STAT_CAP]   & ctrl_reg[CTRL_IE_CAP]);
    end
  end

  assign irq_o = irq_reg;

  // ---------------------------------------------------------------------
  // Optional capture input
  // ---------------------------------------------------------------------
`ifdef WB_TIMER_CAPTURE_EN
  logic [2:0]  cap_sync_reg;
  logic [31:0] capture_reg;

  // [0],[1] synchronise; [2] remembers the previous synchronised level.
  assign cap_rise    = cap_sync_reg[1] & ~cap_sync_reg[2];
  assign capture_val = capture_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cap_sync_reg <= 3'b000;
      capture_reg  <= 32'h0;
    end else begin
      cap_sync_reg <= {cap_sync_reg[1:0], capture_i};
      // Store the value COUNT takes on this edge (third clock after the
      // capture_i edge).
      if (cap_rise) capture_reg <= count_next;
    end
  end

  logic unused_bits;
  assign unused_bits = ^wb_adr_i[1:0];
`else
  assign cap_rise    = 1'b0;
  assign capture_val = 32'h0;

  logic unused_bits;
  assign unused_bits = ^{wb_adr_i[1:0], capture_i};
`endif

endmodule

// File: tb/tb_wb_timer_irq.sv
// Directed testbench for wb_timer_irq.
module tb_wb_timer_irq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        irq_o;
  logic        capture_i;

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;

  wb_timer_irq dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_sel_i  (wb_sel_i),
    .wb_we_i   (wb_we_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_o  (wb_ack_o),
    .irq_o     (irq_o),
    .capture_i (capture_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // All bus tasks start and end 1 ns after a rising edge.
  task automatic wb_write(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk_i); #1;
    check_eq("wr_ack", 32'(wb_ack_o), 32'd1);
    @(posedge clk_i); #1;               // write committed on this edge
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [4:0] adr, output logic [31:0] dat);
    wb_adr_i = adr; wb_sel_i = 4'hF; wb_we_i = 1'b0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk_i); #1;
    check_eq("rd_ack", 32'(wb_ack_o), 32'd1);
    dat = wb_dat_o;
    @(posedge clk_i); #1;
    check_eq("rd_ack_width", 32'(wb_ack_o), 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [4:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(adr, d);
    check_eq(tag, d, exp);
  endtask

  initial begin
    int en_edge, rise1, rise2, target, wedge;
    logic [31:0] cap_exp, cap_stat_exp;

    rst_i = 1'b1; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; capture_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset state
    check_eq("rst_irq", 32'(irq_o), 32'd0);
    check_eq("rst_ack", 32'(wb_ack_o), 32'd0);
    check_eq("rst_dat", wb_dat_o, 32'h0);
    read_check("rst_ctrl",     5'h00, 32'h0);
    read_check("rst_prescale", 5'h04, 32'h0);
    read_check("rst_count",    5'h08, 32'h0);
    read_check("rst_compare",  5'h0C, 32'hFFFF_FFFF);
    read_check("rst_status",   5'h10, 32'h0);
    read_check("rst_capture",  5'h14, 32'h0);
    read_check("unmapped",     5'h18, 32'h0);

    // Byte-lane write into COMPARE
    wb_write(5'h0C, 32'h0000_AB00, 4'b0010);
    read_check("compare_byte", 5'h0C, 32'hFFFF_ABFF);

    // Periodic match with AUTO reload: PRESCALE=3, COMPARE=5
    wb_write(5'h04, 32'd3, 4'hF);
    wb_write(5'h0C, 32'd5, 4'hF);
    wb_write(5'h00, 32'h7, 4'hF);
    en_edge = cyc_cnt;
    rise1 = -1;
    for (int i = 0; i < 40 && rise1 < 0; i++) begin
      @(posedge clk_i); #1;
      if (irq_o) rise1 = cyc_cnt;
    end
    check_eq("match_latency", 32'(rise1 - en_edge), 32'd25);
    read_check("count_reload", 5'h08, 32'h0);
    read_check("status_match", 5'h10, 32'h1);
    wb_write(5'h10, 32'h1, 4'hF);
    check_eq("irq_lag_hold", 32'(irq_o), 32'd1);
    @(posedge clk_i); #1;
    check_eq("irq_clear", 32'(irq_o), 32'd0);
    rise2 = -1;
    for (int i = 0; i < 40 && rise2 < 0; i++) begin
      @(posedge clk_i); #1;
      if (irq_o) rise2 = cyc_cnt;
    end
    check_eq("match_period", 32'(rise2 - rise1), 32'd24);

    // W1C of MATCH on the same edge as a match tick: set wins
    wb_write(5'h10, 32'h1, 4'hF);
    target = en_edge + 72;
    for (int i = 0; i < 40 && cyc_cnt < target - 2; i++) begin
      @(posedge clk_i); #1;
    end
    wb_write(5'h10, 32'h1, 4'hF);
    read_check("w1c_vs_set", 5'h10, 32'h1);
    check_eq("w1c_vs_set_irq", 32'(irq_o), 32'd1);
    wb_write(5'h00, 32'h0, 4'hF);
    wb_write(5'h10, 32'h3, 4'hF);
    @(posedge clk_i); #1;
    check_eq("irq_idle", 32'(irq_o), 32'd0);

    // Overflow: COUNT=FFFF_FFFE, PRESCALE=0, CTRL=EN|IE_OVF
    wb_write(5'h0C, 32'h0000_1000, 4'hF);
    wb_write(5'h04, 32'h0, 4'hF);
    wb_write(5'h08, 32'hFFFF_FFFE, 4'hF);
    wb_write(5'h00, 32'h9, 4'hF);
    wedge = cyc_cnt;
    @(posedge clk_i); @(posedge clk_i); #1;
    check_eq("ovf_irq_lag", 32'(irq_o), 32'd0);
    @(posedge clk_i); #1;
    check_eq("ovf_irq", 32'(irq_o), 32'd1);
    check_eq("ovf_edge", 32'(cyc_cnt - wedge), 32'd3);
    read_check("count_wrapped", 5'h08, 32'h1);
    read_check("status_ovf", 5'h10, 32'h2);
    wb_write(5'h10, 32'h2, 4'hF);
    check_eq("ovf_clr_hold", 32'(irq_o), 32'd1);
    @(posedge clk_i); #1;
    check_eq("ovf_clr_irq", 32'(irq_o), 32'd0);
    wb_write(5'h00, 32'h0, 4'hF);

    // Capture: pulse capture_i while COUNT=0x40, PRESCALE=0
`ifdef WB_TIMER_CAPTURE_EN
    cap_exp = 32'h43; cap_stat_exp = 32'h4;
`else
    cap_exp = 32'h0;  cap_stat_exp = 32'h0;
`endif
    wb_write(5'h08, 32'h40, 4'hF);
    wb_write(5'h10, 32'h7, 4'hF);
    wb_write(5'h00, 32'h1, 4'hF);
    capture_i = 1'b1;
    @(posedge clk_i); @(posedge clk_i); #1;
    capture_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    wb_write(5'h00, 32'h0, 4'hF);
    read_check("capture", 5'h14, cap_exp);
    read_check("status_cap", 5'h10, cap_stat_exp);

    // Asynchronous reset in the middle of a write
    wb_adr_i = 5'h00; wb_dat_i = 32'hF; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk_i); #1;
    check_eq("pre_rst_ack", 32'(wb_ack_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check_eq("async_rst_ack", 32'(wb_ack_o), 32'd0);
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    rst_i = 1'b0;
    read_check("lost_write", 5'h00, 32'h0);
    read_check("rst_compare2", 5'h0C, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
